mux4_rr_arbiter: RTL
====================

# mux4_rr_arbiter

Round-robin controller that shares one 4:1 enabled multiplexer among four requesters. It samples a 4-bit request vector, grants exactly one requester at a time, and drives the select and enable of an internal 4:1 mux so that the granted requester's data bit appears on `Y`. It sits directly in front of the Mux4E datapath: requesters connect `req`/`I`, and consumers read `Y`, `gnt` and `busy`.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner keeps the grant while others wait (timeout build only); legal range ≥ 2.
- `CW`, default `$clog2(MAX_HOLD)`: hold-counter width; derived, do not override.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  4  request vector; `req[i]` high means requester i wants the mux.
- `I`  in  4  data bits; `I[i]` belongs to requester i.
- `gnt`  out  4  one-hot grant, or all-zero when idle; registered.
- `S`  out  2  registered mux select, equal to the granted index.
- `E`  out  1  registered mux enable, high iff `gnt` is non-zero.
- `Y`  out  1  combinational: `E & I[S]`.
- `busy`  out  1  registered, high in state BUSY.

## Operation
- FSM with two states:
  - IDLE: no owner.
  - BUSY: `owner` holds the mux.
- Priority pointer `ptr[1:0]` holds the last granted index. Search order is `ptr+1, ptr+2, ptr+3, ptr` (mod 4), so the previous owner has lowest priority.
- IDLE → BUSY when `req != 0`:
  - `owner` becomes the first set bit in search order.
  - `ptr` becomes `owner`; the hold counter clears.
- IDLE stays IDLE when `req == 0`.
- BUSY, `req[owner]` still high, no forced switch: grant holds and the counter increments, saturating at `MAX_HOLD-1`.
- BUSY, `req[owner]` low:
  - If any other request is pending, grant the next one in search order on the same edge. This is a direct BUSY → BUSY hand-off with no idle cycle.
  - Otherwise go to IDLE.
- Forced switch (`MUX4_ARB_TIMEOUT_EN` only): when counter == `MAX_HOLD-1` and `req` has a bit set other than `owner`, hand off to the next requester in search order, exactly as in a release.
- Pointer wrap-around: index 3 is followed by 0 in search order.
- Only `req` bits differing from `owner` count as "other" requests.
- Mux semantics: `Y = I[S]` when `E=1`, else 0.

## Timing
- Reset values:
  - `gnt=4'b0000`, `S=2'b00`, `E=0`, `busy=0`; `Y=0` follows from `E=0`.
  - State IDLE, `ptr=2'd3` (so requester 0 has first priority), counter 0.
- Reset asserted mid-grant: all of the above take effect immediately (asynchronous) and the grant is dropped.
- Grant latency:
  - `req` sampled at rising edge k; `gnt`/`S`/`E` valid after edge k.
  - `Y` is valid in the cycle after that edge, combinational from `I`.
- Release latency: when `req[owner]` falls before edge k, the grant moves or clears at edge k.
- Simultaneous release and timeout: treat as release; the result is identical.
- Simultaneous requests: resolved in a single cycle by the pointer order.
- With `MAX_HOLD=8` and timeout enabled, a continuously requesting owner holds for exactly 8 cycles while a competitor waits. The competitor's grant appears at the 9th edge after the first grant.

## Configuration
- `MUX4_ARB_TIMEOUT_EN` defined: hold counter and forced switch are compiled in.
- Not defined: counter logic removed; an owner keeps the grant until it drops `req`, and fairness applies only at release. Ports are unchanged.

## Structure
- Package `mux4_arb_pkg` contains:
  - `typedef enum logic {IDLE, BUSY} arb_state_t`
  - `localparam int N_REQ = 4`
  - the default `MAX_HOLD`
  - a function `rr_pick(req, ptr)` returning `{found, idx}`, shared with the bench model.
- One sub-module, `mux4e`: the 4:1 enabled mux (`E`, `I[3:0]`, `S[1:0]` → `Y`), instantiated once and driven by the registered `S`/`E`.

## Test plan
- Reset check: assert `rst` with random `req` → `gnt=0`, `E=0`, `busy=0`, `Y=0`. Then release with `req=4'b1111` → `gnt=4'b0001`, `S=0`.
- Rotation: hold `req=4'b1111` while each owner drops its own request for one cycle after being granted → grant sequence 0, 1, 2, 3, 0 with no idle cycle.
- Pointer priority: grant 2, release, then `req=4'b0101` → grant 0 (search order 3, 0, 1, 2).
- Data path: grant 1 with `I=4'b0010` → `Y=1`; `I=4'b1101` → `Y=0`; with `req=0` → `Y=0` for any `I`.
- Timeout (macro on, `MAX_HOLD=8`): `req[0]` held high and `req[3]` raised at the first grant → `gnt=0001` for 8 cycles, then `1000`. With the macro off, `gnt` stays `0001` indefinitely.
- Async reset mid-grant: assert `rst` between clock edges while `gnt=4'b0100` → outputs clear before the next edge; after release, `req=4'b0100` → grant 2 at the next edge.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared types, constants and the round-robin search used by the mux4_rr_arbiter block.
package mux4_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int N_REQ            = 4;
  localparam int MAX_HOLD_DEFAULT = 8;

  // Returns {found, idx}: first set bit of req in the order ptr+1, ptr+2, ptr+3, ptr.
  function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    onehot = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4e.sv
// 4:1 enabled multiplexer: Y carries I[S] while E is high, otherwise 0.
module mux4e
  import mux4_arb_pkg::*;
(
  input  logic             E,
  input  logic [N_REQ-1:0] I,
  input  logic [1:0]       S,
  output logic             Y
);

  assign Y = E & I[S];

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 enabled mux. Optional hold timeout with
// forced hand-off is compiled in when MUX4_ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int CW       = $clog2(MAX_HOLD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] I,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       S,
  output logic             E,
  output logic             Y,
  output logic             busy
);

  // Handshake: req[i] is requester i's valid and gnt[i] its ready; while both
  // are high I[i] is carried on Y. Dropping req[i] releases the mux at the next
  // edge, where the grant either moves to the next requester or clears.

  arb_state_t       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] others;
  logic [2:0]       pick;
  logic             hand_off;
  logic             new_grant;
  logic             timeout;

  assign others = req & ~onehot(owner_q);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    pick      = 3'b000;
    hand_off  = 1'b0;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        pick = rr_pick(req, ptr_q);
        if (pick[2]) begin
          state_d   = BUSY;
          owner_d   = pick[1:0];
          ptr_d     = pick[1:0];
          new_grant = 1'b1;
        end
      end
      BUSY: begin
        // Release and timeout share one path, so a coincident pair behaves as a release.
        hand_off = ~req[owner_q] | timeout;
        if (hand_off) begin
          pick = rr_pick(others, ptr_q);
          if (pick[2]) begin
            owner_d   = pick[1:0];
            ptr_d     = pick[1:0];
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd3;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= (state_d == BUSY) ? onehot(owner_d) : '0;
    end
  end

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout = (state_q == BUSY) && (cnt_q == HOLD_LAST) && (|others);

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant || (state_d == IDLE)) begin
      cnt_d = '0;
    end else if (cnt_q != HOLD_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // Without the timeout the hold limit has no logic behind it; only its value is kept.
  logic [CW-1:0] unused_hold_cfg;
  logic          unused_new_grant;

  assign unused_hold_cfg  = CW'(MAX_HOLD - 1);
  assign unused_new_grant = new_grant;
  assign timeout          = 1'b0;
`endif

  assign gnt  = gnt_q;
  assign S    = owner_q;
  assign E    = (state_q == BUSY);
  assign busy = (state_q == BUSY);

  mux4e u_mux (
    .E (E),
    .I (I),
    .S (S),
    .Y (Y)
  );

endmodule
